// File: rtl/dotp_pkg.sv
// Shared types and sign-magnitude field constants for the dot-product MAC sequencer.
package dotp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int SIGN_BIT = 16;
  localparam int MAG_W    = 16;
  localparam logic [MAG_W-1:0] MAG_MAX = 16'hFFFF;

endpackage

// File: rtl/dotp_mac_sequencer_if.sv
// Command, activation/weight stream and result handshake bundle of one MAC lane.
interface dotp_mac_sequencer_if #(
  parameter int DATA_W = 17,
  parameter int LEN_W  = 8
) ();

  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              ia_valid_i;
  logic [DATA_W-1:0] ia_data_i;
  logic [DATA_W-1:0] w_data_i;
  logic              ia_ready_o;
  logic              res_valid_o;
  logic [DATA_W-1:0] res_data_o;
  logic              res_ready_i;
  logic              sat_o;

  modport master (
    output start_i, len_i, ia_valid_i, ia_data_i, w_data_i, res_ready_i,
    input  busy_o, ia_ready_o, res_valid_o, res_data_o, sat_o
  );

  modport slave (
    input  start_i, len_i, ia_valid_i, ia_data_i, w_data_i, res_ready_i,
    output busy_o, ia_ready_o, res_valid_o, res_data_o, sat_o
  );

endinterface

// File: rtl/sm_acc_stage.sv
// Accumulate stage: sign-magnitude to two's complement, accumulator add, output clamp.
// DOTP_ACC_SAT_EN selects a saturating accumulator; otherwise it wraps.
module sm_acc_stage
  import dotp_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int ACC_W  = 24
) (
  input  logic                     vld_p1,
  input  logic [DATA_W-1:0]        prod_p1,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  acc_next,
  output logic                     acc_clamp,
  output logic [DATA_W-1:0]        res,
  output logic                     res_clamp
);

  // A magnitude of zero negates to zero, so a "-0" product adds nothing.
  function automatic logic signed [ACC_W-1:0] to_twos(input logic [DATA_W-1:0] sm);
    logic signed [ACC_W-1:0] m;
    m = signed'({{(ACC_W-MAG_W){1'b0}}, sm[MAG_W-1:0]});
    return sm[SIGN_BIT] ? -m : m;
  endfunction

  // Returns {clamp, sign, magnitude}; a negative accumulator is never zero.
  function automatic logic [DATA_W:0] out_conv(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-1:0] mag;
    logic             clamp;
    mag   = a[ACC_W-1] ? -a : a;
    clamp = |mag[ACC_W-1:MAG_W];
    return {clamp, a[ACC_W-1], clamp ? MAG_MAX : mag[MAG_W-1:0]};
  endfunction

`ifdef DOTP_ACC_SAT_EN
  localparam logic signed [ACC_W:0] ACC_MAX = signed'({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] ACC_MIN = signed'({2'b11, {(ACC_W-2){1'b0}}, 1'b1});

  function automatic logic sat_hit(input logic signed [ACC_W:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    logic signed [ACC_W:0] c;
    c = (s > ACC_MAX) ? ACC_MAX : ((s < ACC_MIN) ? ACC_MIN : s);
    return c[ACC_W-1:0];
  endfunction

  logic signed [ACC_W:0] sum;
`endif

  logic signed [ACC_W-1:0] term;
  logic [DATA_W:0]         conv;

  always_comb begin
    term = to_twos(prod_p1);
`ifdef DOTP_ACC_SAT_EN
    sum       = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    acc_clamp = vld_p1 && sat_hit(sum);
    acc_next  = vld_p1 ? sat_acc(sum) : acc;
`else
    acc_clamp = 1'b0;
    acc_next  = vld_p1 ? acc + term : acc;
`endif
    conv      = out_conv(acc);
    res_clamp = conv[DATA_W];
    res       = conv[DATA_W-1:0];
  end

endmodule

// File: rtl/sm_mult.sv
// 17-bit sign-magnitude multiplier: 16x16 magnitude product rounded to 16 bits.
module sm_mult
  import dotp_pkg::*;
#(
  parameter int DATA_W = 17
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);

  function automatic logic [MAG_W-1:0] round_mag(input logic [2*MAG_W-1:0] full);
    logic [MAG_W:0] r;
    r = {1'b0, full[2*MAG_W-1:MAG_W]} + {{MAG_W{1'b0}}, full[MAG_W-1]};
    return r[MAG_W] ? MAG_MAX : r[MAG_W-1:0];
  endfunction

  logic [2*MAG_W-1:0] full;

  always_comb begin
    full = (2*MAG_W)'(a[MAG_W-1:0]) * (2*MAG_W)'(b[MAG_W-1:0]);
    p    = {a[SIGN_BIT] ^ b[SIGN_BIT], round_mag(full)};
  end

endmodule

// File: rtl/dotp_mac_sequencer.sv
// Dot-product sequencer around one sign-magnitude multiplier and a wide accumulator.
// Build option DOTP_ACC_SAT_EN (in sm_acc_stage) makes the accumulator saturate.
module dotp_mac_sequencer
  import dotp_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  dotp_mac_sequencer_if.slave bus
);

  state_t                  state;
  logic [LEN_W-1:0]        len_r;
  logic [LEN_W-1:0]        cnt;
  logic                    busy;
  logic                    ia_ready;
  logic                    res_valid;
  logic [DATA_W-1:0]       res_data;
  logic                    sat;

  logic [DATA_W-1:0]       prod_p0;
  logic [DATA_W-1:0]       prod_p1;
  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_clamp;
  logic [DATA_W-1:0]       res_conv;
  logic                    res_clamp;
  logic                    accept;

  assign accept = bus.ia_valid_i && ia_ready;

  sm_mult #(.DATA_W(DATA_W)) u_mult (
    .a (bus.ia_data_i),
    .b (bus.w_data_i),
    .p (prod_p0)
  );

  sm_acc_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc (
    .vld_p1    (vld_p1),
    .prod_p1   (prod_p1),
    .acc       (acc_p2),
    .acc_next  (acc_next),
    .acc_clamp (acc_clamp),
    .res       (res_conv),
    .res_clamp (res_clamp)
  );

  // Stage 1: registered product
  always_ff @(posedge clk) begin
    if (accept) prod_p1 <= prod_p0;
  end

  // Stage 2 and control: accumulate, sequence, register the result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      ia_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      sat       <= 1'b0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
    end else begin
      vld_p1 <= accept;
      acc_p2 <= acc_next;
      if (acc_clamp) sat <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            busy <= 1'b1;
            sat  <= 1'b0;
            if (bus.len_i != '0) begin
              state    <= RUN;
              ia_ready <= 1'b1;
              len_r    <= bus.len_i;
              cnt      <= '0;
              acc_p2   <= '0;
            end else begin
              state     <= OUT;
              res_valid <= 1'b1;
              res_data  <= '0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if ((cnt + 1'b1) == len_r) begin
              ia_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Stage 2 folds the product in combinationally, so an empty stage 1 means acc is final.
          if (!vld_p1) begin
            res_data  <= res_conv;
            res_valid <= 1'b1;
            if (res_clamp) sat <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (bus.res_ready_i) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy_o      = busy;
  assign bus.ia_ready_o  = ia_ready;
  assign bus.res_valid_o = res_valid;
  assign bus.res_data_o  = res_data;
  assign bus.sat_o       = sat;

endmodule

// File: tb/tb_dotp_mac_sequencer.sv
// Directed bench for dotp_mac_sequencer with a result scoreboard and an independent arithmetic model.
module tb_dotp_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dotp_mac_sequencer_if #(.DATA_W(17), .LEN_W(8)) bus ();

  dotp_mac_sequencer #(.DATA_W(17), .ACC_W(24), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [17:0] sb[$];
  logic [16:0] av[8];
  logic [16:0] wv[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // Reference: exact integer math, rounding by adding half an LSB before the shift.
  function automatic logic [17:0] model(input int n);
    longint acc, m, mag;
    logic   sat;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      m = (longint'(av[i][15:0]) * longint'(wv[i][15:0]) + 32768) >>> 16;
      acc += (av[i][16] ^ wv[i][16]) ? -m : m;
    end
    mag = (acc < 0) ? -acc : acc;
    sat = (mag > 65535);
    if (sat) mag = 65535;
    return {sat, (acc < 0), mag[15:0]};
  endfunction

  task automatic load(input int i, input logic [16:0] a, input logic [16:0] w);
    av[i] = a;
    wv[i] = w;
  endtask

  task automatic start_dot(input int n);
    bus.start_i = 1'b1;
    bus.len_i   = 8'(n);
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ia_valid_i = 1'b1;
      bus.ia_data_i  = av[i];
      bus.w_data_i   = wv[i];
      check("ia_ready", bus.ia_ready_o, 1);
      tick();
      bus.ia_valid_i = 1'b0;
    end
  endtask

  task automatic wait_result();
    int k;
    k = 0;
    while (!bus.res_valid_o && k < 20) begin
      tick();
      k++;
    end
    check("res_valid_arrives", bus.res_valid_o, 1);
  endtask

  task automatic collect(input string tag);
    logic [17:0] want;
    wait_result();
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
    end else begin
      want = sb.pop_front();
      check({tag, "_data"}, bus.res_data_o, want[16:0]);
      check({tag, "_sat"}, bus.sat_o, want[17]);
    end
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    check({tag, "_busy_after"}, bus.busy_o, 0);
    check({tag, "_valid_after"}, bus.res_valid_o, 0);
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.len_i       = '0;
    bus.ia_valid_i  = 1'b0;
    bus.ia_data_i   = '0;
    bus.w_data_i    = '0;
    bus.res_ready_i = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_busy", bus.busy_o, 0);
    check("rst_ready", bus.ia_ready_o, 0);
    check("rst_valid", bus.res_valid_o, 0);
    check("rst_data", bus.res_data_o, 0);
    check("rst_sat", bus.sat_o, 0);
    rst_n = 1'b1;

    // len=1 latency: pair in cycle 1, result valid in cycle 4
    load(0, 17'h08000, 17'h08000);
    start_dot(1);
    check("t1_busy_c1", bus.busy_o, 1);
    check("t1_ready_c1", bus.ia_ready_o, 1);
    send_pairs(1);
    sb.push_back(model(1));
    check("t1_ready_c2", bus.ia_ready_o, 0);
    check("t1_valid_c2", bus.res_valid_o, 0);
    tick();
    check("t1_valid_c3", bus.res_valid_o, 0);
    tick();
    check("t1_valid_c4", bus.res_valid_o, 1);
    collect("t1");

    // mixed signs
    load(0, 17'h08000, 17'h08000);
    load(1, 17'h18000, 17'h08000);
    load(2, 17'h08000, 17'h18000);
    start_dot(3);
    send_pairs(3);
    sb.push_back(model(3));
    collect("mixed");

    // sign-only zero operands
    load(0, 17'h10000, 17'h08000);
    load(1, 17'h08000, 17'h10000);
    load(2, 17'h10000, 17'h10000);
    start_dot(3);
    send_pairs(3);
    sb.push_back(model(3));
    collect("negzero");

    // positive output clamp
    load(0, 17'h0FFFF, 17'h0FFFF);
    load(1, 17'h0FFFF, 17'h0FFFF);
    start_dot(2);
    send_pairs(2);
    sb.push_back(model(2));
    collect("satpos");

    // negative output clamp
    load(0, 17'h1FFFF, 17'h0FFFF);
    load(1, 17'h0FFFF, 17'h1FFFF);
    start_dot(2);
    send_pairs(2);
    sb.push_back(model(2));
    collect("satneg");

    // len=0: immediate zero result, sat cleared
    start_dot(0);
    check("len0_valid_c1", bus.res_valid_o, 1);
    check("len0_busy_c1", bus.busy_o, 1);
    sb.push_back(18'h00000);
    collect("len0");

    // back-pressure hold with start pulses ignored
    load(0, 17'h08000, 17'h18000);
    start_dot(1);
    send_pairs(1);
    sb.push_back(model(1));
    wait_result();
    for (int i = 0; i < 5; i++) begin
      bus.start_i = (i % 2 == 0);
      bus.len_i   = 8'd0;
      tick();
      check("hold_valid", bus.res_valid_o, 1);
      check("hold_data", bus.res_data_o, 17'h14000);
    end
    bus.start_i = 1'b1;
    bus.len_i   = 8'd0;
    collect("hold");
    bus.start_i = 1'b0;
    load(0, 17'h04000, 17'h08000);
    start_dot(1);
    check("restart_busy", bus.busy_o, 1);
    check("restart_ready", bus.ia_ready_o, 1);
    send_pairs(1);
    sb.push_back(model(1));
    collect("restart");

    // reset mid-RUN after 2 of 4 pairs
    for (int i = 0; i < 4; i++) load(i, 17'h08000, 17'h08000);
    start_dot(4);
    send_pairs(2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_ready", bus.ia_ready_o, 0);
    check("mid_rst_valid", bus.res_valid_o, 0);
    check("mid_rst_data", bus.res_data_o, 0);
    check("mid_rst_sat", bus.sat_o, 0);
    rst_n = 1'b1;
    load(0, 17'h08000, 17'h08000);
    start_dot(1);
    send_pairs(1);
    sb.push_back(model(1));
    collect("post_rst");

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dotp_mac_sequencer.md
# dotp_mac_sequencer

Sequences one sign-magnitude fixed-point multiplier through a dot product of programmable length. It accepts a start command and a stream of activation/weight pairs, multiplies each pair, and accumulates the products in a wide two's-complement accumulator. When the last product has been added, it returns one saturated sign-magnitude result. It sits between the activation/weight fetch logic and the output buffer of each convolution lane.

## Interface
- DATA_W, 17: operand/result width; bit 16 is the sign, bits 15:0 are the fractional magnitude.
- ACC_W, 24: accumulator width, two's complement.
- LEN_W, 8: width of the pair-count field (maximum 255 pairs).

- clk  in  1  sole clock; all flops on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  begins a dot product; sampled only in IDLE
- len_i  in  LEN_W  number of pairs; sampled with start_i
- busy_o  out  1  high in every state except IDLE
- ia_valid_i  in  1  a pair is presented
- ia_data_i  in  DATA_W  activation, sign-magnitude
- w_data_i  in  DATA_W  weight, sign-magnitude
- ia_ready_o  out  1  the pair is accepted when valid and ready are both high
- res_valid_o  out  1  result available
- res_data_o  out  DATA_W  result, sign-magnitude
- res_ready_i  in  1  result consumed when valid and ready are both high
- sat_o  out  1  sticky saturation flag for the current result

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE → RUN on start_i with len_i≠0: latch len_i, clear the count, the accumulator and sat_o.
- IDLE → OUT on start_i with len_i=0: the result is 0x00000.
- RUN: ia_ready_o=1. Each accepted pair drives the multiplier: magnitude 16×16; the product magnitude is bits 31:16, rounded up when bit 15 is set; the sign is the XOR of the operand signs. The product is registered in stage 1 with p_valid.
- Stage 2: convert the product to two's complement and add it to the accumulator. A product with magnitude 0 contributes +0 regardless of sign.
- RUN → DRAIN on the cycle the len-th pair is accepted. ia_ready_o=0 from then on.
- DRAIN: wait until stage 1 and stage 2 are empty, then compute res_data_o and enter OUT.
- Output conversion: sign = acc<0; magnitude = |acc| clamped to 0xFFFF. If the clamp occurs, sat_o=1.
- A zero result always has sign 0.
- OUT: res_valid_o and res_data_o stay stable until res_ready_i; on the handshake go to IDLE.
- start_i is ignored in RUN, DRAIN and OUT, including the handshake cycle.
- ia_valid_i outside RUN has no effect.
- Reset values: busy_o=0, ia_ready_o=0, res_valid_o=0, res_data_o=0, sat_o=0; state=IDLE. The pipeline valids and the accumulator are cleared.
- Reset mid-operation aborts with no result and drops in-flight products.

## Timing
- start_i high in cycle 0: busy_o=1 and ia_ready_o=1 from cycle 1.
- At most one pair per cycle. With no bubbles, len pairs are accepted in cycles 1..len.
- Last pair accepted in cycle T: product registered end of T, accumulated end of T+1, result registered end of T+2, res_valid_o=1 in cycle T+3.
- len_i=0: res_valid_o=1 in cycle 1.
- After the result handshake in cycle H: IDLE in H+1; a new start_i is honoured in H+1.
- Throughput: len+4 cycles per dot product with res_ready_i held high.

## Configuration
- DOTP_ACC_SAT_EN defined:
  - each accumulator add saturates to [−2^(ACC_W−1)+1, 2^(ACC_W−1)−1];
  - any accumulator clamp sets sat_o;
  - a saturated negative accumulator never reaches the most-negative code.
- DOTP_ACC_SAT_EN undefined:
  - the accumulator wraps modulo 2^ACC_W;
  - only the output clamp sets sat_o;
  - the most-negative accumulator value outputs 0x1FFFF.

## Structure
- Shared package dotp_pkg holds:
  - the state enum;
  - the sign-magnitude field constants: SIGN_BIT=16, MAG_W=16, MAG_MAX=16'hFFFF.
- The multiplier is the team's existing 17-bit sign-magnitude multiplier, instantiated once.
- One new sub-module, sm_acc_stage, contains the sign-magnitude to two's-complement conversion, the saturating add and the output clamp.

## Test plan
- len=1, pair (0x08000,0x08000) accepted in cycle 1 → res_valid_o in cycle 4, res_data_o=0x04000, sat_o=0.
- len=3, pairs (0x08000,0x08000), (0x18000,0x08000), (0x08000,0x18000) → 0x14000. Repeat with sign-only zero operands (0x10000) → 0x00000.
- len=2, pairs (0x0FFFF,0x0FFFF)×2 → accumulator 0x1FFFC, res_data_o=0x0FFFF, sat_o=1.
- len=0 start → res_valid_o in cycle 1 with 0x00000; busy_o drops after the handshake.
- res_ready_i low for 5 cycles with start_i pulsed → output held stable, start ignored, next start honoured in H+1.
- rst_n low mid-RUN after 2 of 4 pairs → all outputs reset next cycle. A fresh len=1 run returns the correct result with no residue.
